dmem_dump_unit: RTL and testbench

- Parametrised data memory for the processor_arm family, with a built-in dump engine.
- On a dump request, the block walks the array and streams (address, data) pairs over a valid/ready channel, replacing ad-hoc end-of-run memory inspection.
- Sits between the datapath's DM_* signals and the bench/debug sink.
- Generalises width, depth and dump mode.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_dump_unit_if.sv | 22 ++
 rtl/dmem_dump_fsm.sv | 141 ++++++++++++++
 rtl/dmem_dump_unit.sv | 108 ++++++++++
 tb/tb_dmem_dump_unit.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_dump_unit data memory and its dump engine.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    function automatic int byte_off_w(input int n);
        return $clog2(n / 8);
    endfunction

endpackage

// File: rtl/dmem_dump_unit_if.sv
// Dump stream channel: (address, data) words over valid/ready plus last and done markers.
interface dmem_dump_unit_if #(
    parameter int N      = 64,
    parameter int ADDR_W = 5
);
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [N-1:0]      dump_data;
    logic              dump_last;
    logic              dump_done;

    modport master (
        output dump_valid, dump_addr, dump_data, dump_last, dump_done,
        input  dump_ready
    );

    modport slave (
        input  dump_valid, dump_addr, dump_data, dump_last, dump_done,
        output dump_ready
    );
endinterface

// File: rtl/dmem_dump_fsm.sv
// Dump engine: detects the dump request edge, walks the word index and drives the stream.
// DMEM_DIRTY_ONLY_EN restricts the walk to entries written since the last dump.
module dmem_dump_fsm
    import dmem_pkg::*;
#(
    parameter int N      = 64,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump,
    input  logic [N-1:0]      fetch_data_i,
`ifdef DMEM_DIRTY_ONLY_EN
    input  logic [DEPTH-1:0]  dirty_i,
`endif
    output logic [ADDR_W-1:0] idx_o,
    output dump_state_e       state_o,
    output logic              busy_o,
    dmem_dump_unit_if.master  strm
);

    dump_state_e       state_d, state_q;
    logic [ADDR_W-1:0] idx_d, idx_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [N-1:0]      data_d, data_q;
    logic              valid_d, valid_q;
    logic              last_d, last_q;
    logic              done_d, done_q;
    logic              busy_d, busy_q;
    logic              dump_prev_q;
`ifdef DMEM_DIRTY_ONLY_EN
    logic [DEPTH-1:0]  above_s;
    logic              has_above_s;
`endif

    // Next-state, index and stream register computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
`ifdef DMEM_DIRTY_ONLY_EN
        above_s     = (dirty_i >> idx_q) >> 1;
        has_above_s = |above_s;
`endif
        case (state_q)
            IDLE: begin
                if (dump && !dump_prev_q) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
`ifdef DMEM_DIRTY_ONLY_EN
                // Clean entries are stepped over one per cycle; nothing dirty left ends the dump.
                if (dirty_i[idx_q]) begin
                    data_d  = fetch_data_i;
                    addr_d  = idx_q;
                    valid_d = 1'b1;
                    last_d  = !has_above_s;
                    state_d = EMIT;
                end else if (has_above_s) begin
                    idx_d   = idx_q + ADDR_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
`else
                data_d  = fetch_data_i;
                addr_d  = idx_q;
                valid_d = 1'b1;
                last_d  = (idx_q == ADDR_W'(DEPTH - 1));
                state_d = EMIT;
`endif
            end
            EMIT: begin
                if (strm.dump_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = FETCH;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and stream registers; reset drops the stream immediately without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            dump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            dump_prev_q <= dump;
        end
    end

    assign idx_o           = idx_q;
    assign state_o         = state_q;
    assign busy_o          = busy_q;
    assign strm.dump_valid = valid_q;
    assign strm.dump_addr  = addr_q;
    assign strm.dump_data  = data_q;
    assign strm.dump_last  = last_q;
    assign strm.dump_done  = done_q;

endmodule

// File: rtl/dmem_dump_unit.sv
// Word-addressed data memory with a registered read port and a streaming dump engine.
// Optional macro DMEM_DIRTY_ONLY_EN: dump only the entries written since the last dump.
module dmem_dump_unit
    import dmem_pkg::*;
#(
    parameter int N      = 64,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N-1:0]     DM_addr,
    input  logic [N-1:0]     DM_writeData,
    input  logic             DM_writeEnable,
    output logic [N-1:0]     DM_readData,
    output logic             busy,
    input  logic             dump,
    dmem_dump_unit_if.master dump_if
);

    localparam int BOFF = byte_off_w(N);

    logic [N-1:0]      mem_q [DEPTH];
    logic [ADDR_W-1:0] widx_s;
    logic [ADDR_W-1:0] fidx_s;
    dump_state_e       state_s;
    logic              busy_s;
    logic              wr_en_s;
    logic [N-1:0]      rdata_d, rdata_q;
    logic              unused_addr_s;

    // Upper address bits alias onto the array; low bits select a byte within the word.
    assign widx_s        = DM_addr[ADDR_W+BOFF-1:BOFF];
    assign unused_addr_s = ^DM_addr;
    assign wr_en_s       = DM_writeEnable && (state_s == IDLE);

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en_s) begin
            mem_q[widx_s] <= DM_writeData;
        end
    end

    // Read port: old contents on a same-index write, frozen while a dump runs.
    always_comb begin
        rdata_d = rdata_q;
        if (busy_s) begin
            rdata_d = rdata_q;
        end else begin
            rdata_d = mem_q[widx_s];
        end
    end

    // Read data register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

`ifdef DMEM_DIRTY_ONLY_EN
    logic [DEPTH-1:0] dirty_d, dirty_q;

    // Dirty tracking: set by committed writes, wiped once a dump completes.
    always_comb begin
        dirty_d = dirty_q;
        if (state_s == DONE) begin
            dirty_d = '0;
        end else if (wr_en_s) begin
            dirty_d[widx_s] = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Dirty vector register.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            dirty_q <= '0;
        end else begin
            dirty_q <= dirty_d;
        end
    end
`endif

    dmem_dump_fsm #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk          (CLOCK_50),
        .rst_n        (reset),
        .dump         (dump),
        .fetch_data_i (mem_q[fidx_s]),
`ifdef DMEM_DIRTY_ONLY_EN
        .dirty_i      (dirty_q),
`endif
        .idx_o        (fidx_s),
        .state_o      (state_s),
        .busy_o       (busy_s),
        .strm         (dump_if)
    );

    assign DM_readData = rdata_q;
    assign busy        = busy_s;

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Scoreboard bench for dmem_dump_unit: expected stream words are queued at dump start
// and a negedge monitor checks every handshake and done pulse against them.
module tb_dmem_dump_unit;

    typedef struct {
        bit          is_done;
        bit          tchk;
        logic [4:0]  a;
        logic [63:0] d;
        bit          l;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_we;
    logic [63:0] dm_rdata;
    logic        busy;
    logic        dump_r;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          last_hs  = -10;
    bit          held_v   = 1'b0;
    logic [4:0]  held_a   = '0;
    logic [63:0] held_d   = '0;
    exp_t        sb[$];
    logic [63:0] model[32];
    bit          dmodel[32];

    dmem_dump_unit_if #(.N(64), .ADDR_W(5)) sif ();

    dmem_dump_unit #(.N(64), .DEPTH(32)) dut (
        .CLOCK_50       (clk),
        .reset          (rst_n),
        .DM_addr        (dm_addr),
        .DM_writeData   (dm_wdata),
        .DM_writeEnable (dm_we),
        .DM_readData    (dm_rdata),
        .busy           (busy),
        .dump           (dump_r),
        .dump_if        (sif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", nm, cyc);
    endtask

    // Monitor: pops the scoreboard on every handshake and every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (held_v && sif.dump_valid) begin
                check("hold_addr", 64'(sif.dump_addr), 64'(held_a));
                check("hold_data", sif.dump_data, held_d);
            end
            held_v <= sif.dump_valid && !sif.dump_ready;
            held_a <= sif.dump_addr;
            held_d <= sif.dump_data;
            if (sif.dump_valid && sif.dump_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = sb.pop_front();
                    check("word_kind", 64'(e.is_done), 64'd0);
                    check("word_addr", 64'(sif.dump_addr), 64'(e.a));
                    check("word_data", sif.dump_data, e.d);
                    check("word_last", 64'(sif.dump_last), 64'(e.l));
                    if (sif.dump_last) last_hs <= cyc;
                end
            end
            if (sif.dump_done) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb.pop_front();
                    check("done_kind", 64'(e.is_done), 64'd1);
                    if (e.tchk) check("done_timing", 64'(cyc), 64'(last_hs + 1));
                end
            end
        end
    end

    task automatic wr(input int i, input logic [63:0] d);
        dm_addr  = 64'(i * 8);
        dm_wdata = d;
        dm_we    = 1'b1;
        model[i]  = d;
        dmodel[i] = 1'b1;
        @(posedge clk); #1;
        dm_we = 1'b0;
    endtask

    task automatic rd_check(input string nm, input int i, input logic [63:0] exp);
        dm_addr = 64'(i * 8);
        @(posedge clk); #1;
        check(nm, dm_rdata, exp);
    endtask

    task automatic fill();
        for (int i = 0; i < 32; i++) wr(i, 64'(i * 7));
    endtask

    // Queue what the next dump should stream, given the bench's memory model.
    task automatic push_dump();
        exp_t e;
        int   hi;
        hi = -1;
        for (int i = 0; i < 32; i++) begin
`ifdef DMEM_DIRTY_ONLY_EN
            if (dmodel[i]) hi = i;
`else
            hi = i;
`endif
        end
        for (int i = 0; i <= hi; i++) begin
`ifdef DMEM_DIRTY_ONLY_EN
            if (!dmodel[i]) continue;
`endif
            e = '{is_done: 1'b0, tchk: 1'b0, a: 5'(i), d: model[i], l: (i == hi)};
            sb.push_back(e);
        end
        e = '{is_done: 1'b1, tchk: (hi >= 0), a: 5'd0, d: 64'd0, l: 1'b0};
        sb.push_back(e);
        for (int i = 0; i < 32; i++) dmodel[i] = 1'b0;
    endtask

    task automatic pulse();
        dump_r = 1'b1;
        @(posedge clk); #1;
        dump_r = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget, input bit toggle);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            if (toggle) sif.dump_ready = ~sif.dump_ready;
            @(posedge clk); #1;
            n++;
        end
        check(nm, 64'(n < budget), 64'd1);
        sif.dump_ready = 1'b1;
    endtask

    initial begin
        int  n;
        bit  found;
        rst_n          = 1'b0;
        dm_addr        = 64'd0;
        dm_wdata       = 64'd0;
        dm_we          = 1'b0;
        dump_r         = 1'b0;
        sif.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            model[i]  = 64'd0;
            dmodel[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(sif.dump_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(sif.dump_done), 64'd0);
        check("rst_last", 64'(sif.dump_last), 64'd0);
        check("rst_addr", 64'(sif.dump_addr), 64'd0);
        check("rst_data", sif.dump_data, 64'd0);
        check("rst_rdata", dm_rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write/read of word 3 through byte address 24.
        wr(3, 64'hDEAD_BEEF_0000_0003);
        rd_check("rd_word3", 3, 64'hDEAD_BEEF_0000_0003);

        // Full dump, sink always ready.
        fill();
        rd_check("rd_word31", 31, 64'd217);
        push_dump();
        pulse();
        check("busy_in_dump", 64'(busy), 64'd1);
        drain("drain_full", 400, 1'b0);

        // Full dump with ready toggling every cycle.
        fill();
        push_dump();
        pulse();
        drain("drain_toggle", 600, 1'b1);

        // Datapath write during a dump must be dropped.
        fill();
        push_dump();
        pulse();
        repeat (3) @(posedge clk);
        #1;
        dm_addr  = 64'd40;
        dm_wdata = 64'd1;
        dm_we    = 1'b1;
        check("busy_blocks_wr", 64'(busy), 64'd1);
        @(posedge clk); #1;
        dm_we = 1'b0;
        drain("drain_wrblock", 400, 1'b0);
        rd_check("rd_word5_kept", 5, 64'd35);

        // Reset while word 10 is presented.
        fill();
        for (int i = 0; i < 10; i++) begin
            sb.push_back('{is_done: 1'b0, tchk: 1'b0, a: 5'(i), d: model[i], l: 1'b0});
        end
        pulse();
        found = 1'b0;
        n = 0;
        while (!found && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (sif.dump_valid && sif.dump_addr == 5'd10) begin
                sif.dump_ready = 1'b0;
                found = 1'b1;
            end
        end
        check("reach_addr10", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(sif.dump_valid), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(sif.dump_done), 64'd0);
        check("rst_mid_sb", 64'(sb.size()), 64'd0);
        sb.delete();
        for (int i = 0; i < 32; i++) dmodel[i] = 1'b0;
        @(posedge clk); #1;
        rst_n          = 1'b1;
        sif.dump_ready = 1'b1;
        @(posedge clk); #1;
`ifdef DMEM_DIRTY_ONLY_EN
        fill();
`endif
        push_dump();
        pulse();
        drain("drain_restart", 400, 1'b0);

        // Write and dump edge in the same IDLE cycle: the stream carries the new value.
        dm_addr  = 64'd0;
        dm_wdata = 64'h0123_4567_89AB_CDEF;
        dm_we    = 1'b1;
        dump_r   = 1'b1;
        model[0]  = 64'h0123_4567_89AB_CDEF;
        dmodel[0] = 1'b1;
        push_dump();
        @(posedge clk); #1;
        dm_we  = 1'b0;
        dump_r = 1'b0;
        drain("drain_simul", 400, 1'b0);

`ifdef DMEM_DIRTY_ONLY_EN
        // Only the two dirty words stream; an immediate second dump is empty.
        wr(2, 64'h0000_0000_0000_00A2);
        wr(9, 64'h0000_0000_0000_00A9);
        push_dump();
        pulse();
        drain("drain_dirty", 200, 1'b0);
        push_dump();
        pulse();
        drain("drain_empty", 200, 1'b0);
`endif

        check("end_busy", 64'(busy), 64'd0);
        check("end_valid", 64'(sif.dump_valid), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
